// File: rtl/pst_if_fetch_queue.sv
// Instruction fetch stage with a decoupling queue of {pc, pc_4, inst} entries.
// Prioritised redirects flush the queue and restart fetch at the new target.
module pst_if_fetch_queue #(
    parameter int                   ADDR_NBIT = 10,
    parameter int                   DEPTH     = 4,
    parameter int                   NREDIR    = 2,
    parameter logic [ADDR_NBIT-1:0] RESET_PC  = '0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic [NREDIR-1:0]             redir_valid,
    input  logic [NREDIR*ADDR_NBIT-1:0]   redir_pc,
    output logic [ADDR_NBIT-1:0]          imem_addr,
    input  logic [31:0]                   imem_inst,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ADDR_NBIT-1:0]          out_pc,
    output logic [ADDR_NBIT-1:0]          out_pc_4,
    output logic [31:0]                   out_inst,
    output logic [$clog2(DEPTH):0]        count
);

    localparam int PTR_NBIT = $clog2(DEPTH);
    localparam int CNT_NBIT = PTR_NBIT + 1;
    localparam logic [CNT_NBIT-1:0] DEPTH_C = CNT_NBIT'(DEPTH);

    typedef struct packed {
        logic [ADDR_NBIT-1:0] pc;
        logic [ADDR_NBIT-1:0] pc_4;
        logic [31:0]          inst;
    } entry_t;

    logic [ADDR_NBIT-1:0] r_fetch_pc;
    logic [PTR_NBIT-1:0]  r_rd_ptr;
    logic [PTR_NBIT-1:0]  r_wr_ptr;
    logic [CNT_NBIT-1:0]  r_count;
    entry_t               r_mem [DEPTH];

    logic [ADDR_NBIT-1:0] w_redir_pc;
    logic [ADDR_NBIT-1:0] w_pc_4;
    logic                 w_redir_any;
    logic                 w_out_valid;
    logic                 w_pop;
    logic                 w_push;

    // NOTE: the descending loop with blocking assignments lets the lowest asserted index win.
    always_comb begin
        w_redir_pc = '0;
        for (int i = NREDIR - 1; i >= 0; i--) begin
            if (redir_valid[i]) begin
                w_redir_pc = redir_pc[i*ADDR_NBIT +: ADDR_NBIT];
            end
        end
    end

    assign w_redir_any = en & (|redir_valid);
    assign w_out_valid = en & (r_count != '0) & ~w_redir_any;
    assign w_pop       = w_out_valid & out_ready;
    assign w_push      = en & ~w_redir_any & ((r_count < DEPTH_C) | w_pop);
    assign w_pc_4      = r_fetch_pc + ADDR_NBIT'(4);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fetch_pc <= RESET_PC;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else if (w_redir_any) begin
            r_fetch_pc <= w_redir_pc;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else begin
            if (w_push) begin
                r_fetch_pc <= w_pc_4;
                r_wr_ptr   <= r_wr_ptr + PTR_NBIT'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_NBIT'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_NBIT'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_NBIT'(1);
            end
        end
    end

    // NOTE: queue storage has no reset; pointers and count alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= '{pc: r_fetch_pc, pc_4: w_pc_4, inst: imem_inst};
        end
    end

    assign imem_addr = r_fetch_pc;
    assign out_valid = w_out_valid;
    assign out_pc    = r_mem[r_rd_ptr].pc;
    assign out_pc_4  = r_mem[r_rd_ptr].pc_4;
    assign out_inst  = r_mem[r_rd_ptr].inst;
    assign count     = r_count;

endmodule

// File: tb/tb_pst_if_fetch_queue.sv
// Directed bench for pst_if_fetch_queue: inputs driven and outputs sampled
// just after the falling edge, one task per scenario.
module tb_pst_if_fetch_queue;

    localparam int ADDR_NBIT = 10;
    localparam int DEPTH     = 4;
    localparam int NREDIR    = 2;

    logic                        clk = 1'b0;
    logic                        rst_n;
    logic                        en;
    logic [NREDIR-1:0]           redir_valid;
    logic [NREDIR*ADDR_NBIT-1:0] redir_pc;
    logic [ADDR_NBIT-1:0]        imem_addr;
    logic [31:0]                 imem_inst;
    logic                        out_valid;
    logic                        out_ready;
    logic [ADDR_NBIT-1:0]        out_pc;
    logic [ADDR_NBIT-1:0]        out_pc_4;
    logic [31:0]                 out_inst;
    logic [$clog2(DEPTH):0]      count;

    int n_tests = 0;
    int n_fail  = 0;

    pst_if_fetch_queue #(
        .ADDR_NBIT(ADDR_NBIT),
        .DEPTH    (DEPTH),
        .NREDIR   (NREDIR),
        .RESET_PC ('0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .redir_valid(redir_valid),
        .redir_pc   (redir_pc),
        .imem_addr  (imem_addr),
        .imem_inst  (imem_inst),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pc     (out_pc),
        .out_pc_4   (out_pc_4),
        .out_inst   (out_inst),
        .count      (count)
    );

    always #5 clk = ~clk;

    // Instruction memory model: the word is derived from its address.
    assign imem_inst = 32'hA5A5_0000 | {22'd0, imem_addr};

    function automatic logic [31:0] exp_inst(input logic [ADDR_NBIT-1:0] pc);
        return 32'hA5A5_0000 | {22'd0, pc};
    endfunction

    task automatic go();
        @(negedge clk);
    endtask

    task automatic chk_head(input string name, input logic [ADDR_NBIT-1:0] pc,
                            input logic [ADDR_NBIT-1:0] pc_4);
        n_tests++;
        if (out_valid !== 1'b1 || out_pc !== pc || out_pc_4 !== pc_4 || out_inst !== exp_inst(pc)) begin
            n_fail++;
            $display("FAIL %s: valid=%b pc=%h pc_4=%h inst=%h, expected valid=1 pc=%h pc_4=%h inst=%h",
                     name, out_valid, out_pc, out_pc_4, out_inst, pc, pc_4, exp_inst(pc));
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; out_ready = 1'b1; redir_valid = '0; redir_pc = '0;
        go(); go(); #1;
        n_tests++;
        if (count !== 3'd0 || out_valid !== 1'b0 || imem_addr !== 10'h000) begin
            n_fail++;
            $display("FAIL reset_state: count=%0d valid=%b addr=%h, expected 0 0 000", count, out_valid, imem_addr);
        end
        rst_n = 1'b1; #1;
        n_tests++;
        if (out_valid !== 1'b0 || imem_addr !== 10'h000) begin
            n_fail++;
            $display("FAIL reset_first_cycle: valid=%b addr=%h, expected 0 000", out_valid, imem_addr);
        end
    endtask

    task automatic test_stream();
        for (int k = 0; k < 6; k++) begin
            go(); #1;
            chk_head($sformatf("stream[%0d]", k), ADDR_NBIT'(4 * k), ADDR_NBIT'(4 * k + 4));
            n_tests++;
            if (count !== 3'd1) begin
                n_fail++;
                $display("FAIL stream_count[%0d]: count=%0d, expected 1", k, count);
            end
        end
    endtask

    task automatic test_backpressure();
        go(); out_ready = 1'b0; redir_valid = 2'b01; redir_pc = {10'h000, 10'h000}; #1;
        go(); redir_valid = '0; #1;
        n_tests++;
        if (count !== 3'd0 || imem_addr !== 10'h000) begin
            n_fail++;
            $display("FAIL bp_start: count=%0d addr=%h, expected 0 000", count, imem_addr);
        end
        for (int j = 1; j <= 5; j++) begin
            go(); #1;
            n_tests++;
            if (count !== 3'((j > 4) ? 4 : j) || imem_addr !== ADDR_NBIT'(4 * ((j > 4) ? 4 : j))) begin
                n_fail++;
                $display("FAIL bp_fill[%0d]: count=%0d addr=%h, expected %0d %h", j, count, imem_addr,
                         (j > 4) ? 4 : j, 4 * ((j > 4) ? 4 : j));
            end
        end
        go(); out_ready = 1'b1; #1;
        chk_head("bp_full_head", 10'h000, 10'h004);
        go(); out_ready = 1'b0; #1;
        n_tests++;
        if (count !== 3'd4 || out_pc !== 10'h004 || imem_addr !== 10'h014) begin
            n_fail++;
            $display("FAIL bp_push_pop_full: count=%0d pc=%h addr=%h, expected 4 004 014", count, out_pc, imem_addr);
        end
    endtask

    task automatic test_redirect_priority();
        go(); redir_valid = 2'b01; redir_pc = {10'h000, 10'h040}; #1;
        go(); redir_valid = '0; #1;
        go(); go();
        go(); redir_valid = 2'b11; redir_pc = {10'h200, 10'h100}; #1;
        n_tests++;
        if (out_valid !== 1'b0 || count !== 3'd3) begin
            n_fail++;
            $display("FAIL prio_same_cycle: valid=%b count=%0d, expected 0 3", out_valid, count);
        end
        go(); redir_valid = '0; out_ready = 1'b1; #1;
        n_tests++;
        if (count !== 3'd0 || imem_addr !== 10'h100) begin
            n_fail++;
            $display("FAIL prio_flush: count=%0d addr=%h, expected 0 100", count, imem_addr);
        end
        go(); #1;
        chk_head("prio_head", 10'h100, 10'h104);
        go(); #1;
        chk_head("prio_next", 10'h104, 10'h108);
    endtask

    task automatic test_wrap();
        go(); redir_valid = 2'b10; redir_pc = {10'h3FC, 10'h080}; #1;
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_redir_valid: valid=%b, expected 0", out_valid);
        end
        go(); redir_valid = '0; #1;
        n_tests++;
        if (imem_addr !== 10'h3FC) begin
            n_fail++;
            $display("FAIL wrap_fetch: addr=%h, expected 3fc", imem_addr);
        end
        go(); #1;
        chk_head("wrap_3fc", 10'h3FC, 10'h000);
        go(); #1;
        chk_head("wrap_000", 10'h000, 10'h004);
    endtask

    task automatic test_en_gating();
        for (int j = 0; j < 3; j++) begin
            go(); en = 1'b0;
            redir_valid = (j == 1) ? 2'b01 : 2'b00;
            redir_pc = {10'h000, 10'h300};
            #1;
            n_tests++;
            if (out_valid !== 1'b0 || count !== 3'd1 || imem_addr !== 10'h008) begin
                n_fail++;
                $display("FAIL en_hold[%0d]: valid=%b count=%0d addr=%h, expected 0 1 008", j, out_valid, count, imem_addr);
            end
        end
        go(); en = 1'b1; redir_valid = '0; #1;
        chk_head("en_resume", 10'h004, 10'h008);
        go(); #1;
        chk_head("en_next", 10'h008, 10'h00C);
    endtask

    task automatic test_reset_mid();
        go(); out_ready = 1'b0;
        go(); go();
        go(); #1;
        n_tests++;
        if (count !== 3'd4) begin
            n_fail++;
            $display("FAIL mid_full: count=%0d, expected 4", count);
        end
        go(); rst_n = 1'b0; redir_valid = 2'b01; redir_pc = {10'h000, 10'h200};
        go(); rst_n = 1'b1; redir_valid = '0; out_ready = 1'b1; #1;
        n_tests++;
        if (count !== 3'd0 || out_valid !== 1'b0 || imem_addr !== 10'h000) begin
            n_fail++;
            $display("FAIL mid_reset: count=%0d valid=%b addr=%h, expected 0 0 000", count, out_valid, imem_addr);
        end
        go(); #1;
        chk_head("mid_first", 10'h000, 10'h004);
        go(); #1;
        chk_head("mid_second", 10'h004, 10'h008);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_priority();
        test_wrap();
        test_en_gating();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
